// File: rtl/fetch_pkg.sv
// Shared types and helpers for the instruction fetch unit: FSM state encoding,
// instruction-queue entry layout and small arithmetic helpers.
package fetch_pkg;

  localparam int INSTR_BYTES     = 4;
  localparam int DEF_ADDR_WIDTH  = 32;
  localparam int DEF_INSTR_WIDTH = 32;

  typedef enum logic [2:0] {
    ST_RUN,
    ST_MISS_REQ,
    ST_MISS_WAIT,
    ST_FILL,
    ST_DRAIN
  } fetch_state_t;

  // Default entry layout; the top re-declares it with its own widths.
  typedef struct packed {
    logic [DEF_INSTR_WIDTH-1:0] instr;
    logic [DEF_ADDR_WIDTH-1:0]  pc;
  } iq_entry_t;

  function automatic int min3(input int a, input int b, input int c);
    int m;
    m = (a < b) ? a : b;
    return (m < c) ? m : c;
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Circular instruction queue: up to FETCH_WIDTH in-order enqueues per cycle,
// one dequeue per cycle, synchronous flush that empties the queue.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter type entry_t      = iq_entry_t,
  parameter int  FETCH_WIDTH  = 2,
  parameter int  IQ_DEPTH     = 8,
  localparam int PTR_W        = (IQ_DEPTH > 1) ? $clog2(IQ_DEPTH) : 1,
  localparam int CNT_W        = $clog2(IQ_DEPTH + 1),
  localparam int ENQ_W        = $clog2(FETCH_WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_aH,
  input  logic             flush,
  input  logic [ENQ_W-1:0] enq_count,
  input  entry_t           enq_data [FETCH_WIDTH],
  input  logic             deq,
  output logic             valid,
  output entry_t           head,
  output logic [CNT_W-1:0] count
);

  entry_t           mem [IQ_DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count_q;
  logic             deq_fire;

  assign valid    = (count_q != '0);
  assign head     = mem[rd_ptr];
  assign count    = count_q;
  assign deq_fire = deq && valid;

  // NOTE: storage is deliberately not reset; count_q alone decides which slots are live.
  always_ff @(posedge clk) begin
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      if (!flush && (ENQ_W'(i) < enq_count)) begin
        mem[wr_ptr + PTR_W'(i)] <= enq_data[i];
      end
    end
  end

  // A dequeue in a flush cycle is simply absorbed: everything is discarded.
  always_ff @(posedge clk or posedge rst_aH) begin
    if (rst_aH) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
    end else if (flush) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
    end else begin
      wr_ptr  <= wr_ptr + PTR_W'(enq_count);
      rd_ptr  <= rd_ptr + PTR_W'(deq_fire);
      count_q <= count_q + CNT_W'(enq_count) - CNT_W'(deq_fire);
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: owns the PC, enqueues cache-hit instructions into
// the fetch queue and refills missing blocks from DRAM via a small FSM.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int                  ADDR_WIDTH   = 32,
  parameter int                  INSTR_WIDTH  = 32,
  parameter int                  BLOCK_INSTRS = 2,
  parameter int                  FETCH_WIDTH  = 2,
  parameter int                  IQ_DEPTH     = 8,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                                clk,
  input  logic                                rst_aH,
  input  logic [ADDR_WIDTH-1:0]               recovery_PC,
  input  logic                                recovery_PC_valid,
  input  logic                                fetch_stall,
  output logic [ADDR_WIDTH-1:0]               icache_addr,
  input  logic                                icache_hit,
  input  logic [BLOCK_INSTRS*INSTR_WIDTH-1:0] icache_block,
  output logic                                icache_fill_we,
  output logic [ADDR_WIDTH-1:0]               icache_fill_addr,
  output logic [BLOCK_INSTRS*INSTR_WIDTH-1:0] icache_fill_data,
  output logic                                dram_req_valid,
  input  logic                                dram_req_ready,
  output logic [ADDR_WIDTH-1:0]               dram_req_addr,
  input  logic                                dram_resp_valid,
  input  logic [BLOCK_INSTRS*INSTR_WIDTH-1:0] dram_resp_data,
  input  logic                                instr_ready,
  output logic                                instr_valid,
  output logic [INSTR_WIDTH-1:0]              instr_data,
  output logic [ADDR_WIDTH-1:0]               instr_PC
);

  localparam int BLOCK_W     = BLOCK_INSTRS * INSTR_WIDTH;
  localparam int BLOCK_BYTES = BLOCK_INSTRS * INSTR_BYTES;
  localparam int SLOT_W      = (BLOCK_INSTRS > 1) ? $clog2(BLOCK_INSTRS) : 1;
  localparam int CNT_W       = $clog2(IQ_DEPTH + 1);
  localparam int ENQ_W       = $clog2(FETCH_WIDTH + 1);

  typedef struct packed {
    logic [INSTR_WIDTH-1:0] instr;
    logic [ADDR_WIDTH-1:0]  pc;
  } entry_t;

  fetch_state_t          state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [ADDR_WIDTH-1:0] miss_addr_q, miss_addr_d;
  logic [BLOCK_W-1:0]    fill_data_q, fill_data_d;

  logic [SLOT_W-1:0]     slot;
  int                    n_max;
  logic [ENQ_W-1:0]      enq_n;
  entry_t                enq_data [FETCH_WIDTH];
  logic                  flush;
  logic [CNT_W-1:0]      q_count;
  logic                  q_valid;
  entry_t                q_head;

  // Word slot within the block and the most we may take this cycle.
  assign slot  = pc_q[SLOT_W+1:2] & SLOT_W'(BLOCK_INSTRS - 1);
  assign n_max = min3(FETCH_WIDTH, BLOCK_INSTRS - int'(slot), IQ_DEPTH - int'(q_count));

  always_comb begin
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      int idx;
      idx = int'(slot) + i;
      if (idx >= BLOCK_INSTRS) idx = 0;
      enq_data[i].instr = icache_block[idx*INSTR_WIDTH +: INSTR_WIDTH];
      enq_data[i].pc    = pc_q + ADDR_WIDTH'(INSTR_BYTES * i);
    end
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    miss_addr_d = miss_addr_q;
    fill_data_d = fill_data_q;
    enq_n       = '0;
    flush       = recovery_PC_valid;

    unique case (state_q)
      ST_RUN: begin
        if (!recovery_PC_valid && !fetch_stall) begin
          if (icache_hit) begin
            enq_n = ENQ_W'(n_max);
            pc_d  = pc_q + ADDR_WIDTH'(INSTR_BYTES * n_max);
          end else begin
            miss_addr_d = pc_q & ~ADDR_WIDTH'(BLOCK_BYTES - 1);
            state_d     = ST_MISS_REQ;
          end
        end
      end
      ST_MISS_REQ: begin
        if (recovery_PC_valid)   state_d = ST_RUN;
        else if (dram_req_ready) state_d = ST_MISS_WAIT;
      end
      ST_MISS_WAIT: begin
        if (dram_resp_valid) begin
          if (recovery_PC_valid) begin
            state_d = ST_RUN;
          end else begin
            fill_data_d = dram_resp_data;
            state_d     = ST_FILL;
          end
        end else if (recovery_PC_valid) begin
          state_d = ST_DRAIN;
        end
      end
      ST_FILL:  state_d = ST_RUN;
      // The response still owed by DRAM belongs to a squashed path.
      ST_DRAIN: if (dram_resp_valid) state_d = ST_RUN;
      default:  state_d = ST_RUN;
    endcase

    if (recovery_PC_valid) pc_d = recovery_PC;
  end

  // NOTE: state registers use non-blocking assignments so all update together at the edge.
  always_ff @(posedge clk or posedge rst_aH) begin
    if (rst_aH) begin
      state_q     <= ST_RUN;
      pc_q        <= RESET_PC;
      miss_addr_q <= '0;
      fill_data_q <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      miss_addr_q <= miss_addr_d;
      fill_data_q <= fill_data_d;
    end
  end

  fetch_queue #(
    .entry_t    (entry_t),
    .FETCH_WIDTH(FETCH_WIDTH),
    .IQ_DEPTH   (IQ_DEPTH)
  ) u_queue (
    .clk      (clk),
    .rst_aH   (rst_aH),
    .flush    (flush),
    .enq_count(enq_n),
    .enq_data (enq_data),
    .deq      (instr_ready),
    .valid    (q_valid),
    .head     (q_head),
    .count    (q_count)
  );

  assign icache_addr      = pc_q;
  assign dram_req_valid   = (state_q == ST_MISS_REQ);
  assign dram_req_addr    = miss_addr_q;
  assign icache_fill_we   = (state_q == ST_FILL);
  assign icache_fill_addr = miss_addr_q;
  assign icache_fill_data = fill_data_q;
  assign instr_valid      = q_valid;
  assign instr_data       = q_head.instr;
  assign instr_PC         = q_head.pc;

endmodule
